// File: rtl/uart_cmd_rx_pkg.sv
// Shared types and constants for the UART command receiver.
// The PARITY state exists only when UART_CMD_PARITY_EN is defined.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_CMD_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_CLR,
    CMD_RUN,
    CMD_MODE
  } cmd_t;

  localparam logic [7:0] CMD_CLEAR_U   = 8'h43;
  localparam logic [7:0] CMD_CLEAR_L   = 8'h63;
  localparam logic [7:0] CMD_RUNSTOP_U = 8'h52;
  localparam logic [7:0] CMD_RUNSTOP_L = 8'h72;
  localparam logic [7:0] CMD_MODE_U    = 8'h4D;
  localparam logic [7:0] CMD_MODE_L    = 8'h6D;

  localparam logic [3:0] MID_TICK = 4'd7;

  function automatic cmd_t decode_cmd(input logic [7:0] b);
    case (b)
      CMD_CLEAR_U,   CMD_CLEAR_L:   decode_cmd = CMD_CLR;
      CMD_RUNSTOP_U, CMD_RUNSTOP_L: decode_cmd = CMD_RUN;
      CMD_MODE_U,    CMD_MODE_L:    decode_cmd = CMD_MODE;
      default:                      decode_cmd = CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_rx_baud_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every CLK_HZ/(BAUD*OVERSAMPLE) clocks.
module baud_tick_gen #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == DIV_LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART receiver with ASCII command decode (C/R/M) for stopwatch control.
// Define UART_CMD_PARITY_EN for 8E1 framing; default is 8N1.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       o_btn_clear,
  output logic       o_btn_runstop,
  output logic       o_sw_mode,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  logic       rx_meta, rx_s;
  logic       tick;
  rx_state_t  state, state_d;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       par_err;

  logic cnt_clr, cnt_inc, bit_clr, shift_en, good, ferr;
`ifdef UART_CMD_PARITY_EN
  logic par_smp;
`endif

  // Both stages reset high so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  baud_tick_gen #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    good     = 1'b0;
    ferr     = 1'b0;
`ifdef UART_CMD_PARITY_EN
    par_smp  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_clr = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tick_cnt == MID_TICK) begin
            cnt_clr = 1'b1;
            if (!rx_s) begin
              state_d = ST_DATA;
              bit_clr = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tick_cnt == LAST_TICK) begin
            shift_en = 1'b1;
            cnt_clr  = 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
`ifdef UART_CMD_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (tick_cnt == LAST_TICK) begin
            par_smp = 1'b1;
            cnt_clr = 1'b1;
            state_d = ST_STOP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (tick_cnt == LAST_TICK) begin
            cnt_clr = 1'b1;
            if (rx_s) begin
              // Parity-only failures go straight back to IDLE; line is already high.
              good    = !par_err;
              ferr    = par_err;
              state_d = ST_IDLE;
            end else begin
              ferr    = 1'b1;
              state_d = ST_WAIT_IDLE;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_rx_data   <= 8'h00;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      if (cnt_clr)      tick_cnt <= '0;
      else if (cnt_inc) tick_cnt <= tick_cnt + 4'd1;
      if (bit_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en) shift <= {rx_s, shift[7:1]};
      if (good)     o_rx_data <= shift;
      o_rx_valid  <= good;
      o_frame_err <= ferr;
    end
  end

`ifdef UART_CMD_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  always_ff @(posedge clk) begin
    if (reset)        par_err <= 1'b0;
    else if (bit_clr) par_err <= 1'b0;
    else if (par_smp) par_err <= (^shift) ^ rx_s;
  end
`else
  assign par_err = 1'b0;
`endif

  cmd_t cmd;
  assign cmd = decode_cmd(o_rx_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      o_btn_clear   <= 1'b0;
      o_btn_runstop <= 1'b0;
      o_sw_mode     <= 1'b0;
    end else begin
      o_btn_clear   <= o_rx_valid && (cmd == CMD_CLR);
      o_btn_runstop <= o_rx_valid && (cmd == CMD_RUN);
      if (o_rx_valid && (cmd == CMD_MODE)) o_sw_mode <= ~o_sw_mode;
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: stimulus queues expected events, monitor pops and compares.
module tb_uart_cmd_rx;

  localparam int BAUD       = 9600;
  localparam int OVERSAMPLE = 16;
  localparam int DIVN       = 4;
  localparam int CLK_HZ     = BAUD * OVERSAMPLE * DIVN;
  localparam int BIT        = OVERSAMPLE * DIVN;

  localparam int EV_VALID = 0;
  localparam int EV_FERR  = 1;
  localparam int EV_CLEAR = 2;
  localparam int EV_RUN   = 3;
  localparam int EV_MODE  = 4;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       o_btn_clear, o_btn_runstop, o_sw_mode, o_rx_valid, o_frame_err;
  logic [7:0] o_rx_data;

  uart_cmd_rx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .o_btn_clear  (o_btn_clear),
    .o_btn_runstop(o_btn_runstop),
    .o_sw_mode    (o_sw_mode),
    .o_rx_data    (o_rx_data),
    .o_rx_valid   (o_rx_valid),
    .o_frame_err  (o_frame_err)
  );

  always #5 clk = ~clk;

  ev_t q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  bit  mon_hold = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] data);
    ev_t e;
    if (q.size() == 0) begin
      chk("unexpected_event", kind, -1);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_data", int'(data), int'(e.data));
    end
  endtask

  // Monitor
  logic valid_q = 1'b0, clr_q = 1'b0, run_q = 1'b0, mode_q = 1'b0;
  always @(negedge clk) begin
    if (!mon_hold) begin
      if (o_rx_valid)  expect_ev(EV_VALID, o_rx_data);
      if (o_frame_err) expect_ev(EV_FERR, 8'h00);
      if (o_btn_clear) begin
        expect_ev(EV_CLEAR, 8'h00);
        chk("clear_after_valid", int'(valid_q), 1);
        chk("clear_width", int'(clr_q), 0);
      end
      if (o_btn_runstop) begin
        expect_ev(EV_RUN, 8'h00);
        chk("runstop_after_valid", int'(valid_q), 1);
        chk("runstop_width", int'(run_q), 0);
      end
      if (o_btn_clear || o_btn_runstop)
        chk("clear_runstop_exclusive", int'(o_btn_clear && o_btn_runstop), 0);
      if (o_sw_mode != mode_q) begin
        expect_ev(EV_MODE, {7'd0, o_sw_mode});
        chk("mode_after_valid", int'(valid_q), 1);
      end
    end
    valid_q = o_rx_valid;
    clr_q   = o_btn_clear;
    run_q   = o_btn_runstop;
    mode_q  = o_sw_mode;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // stop_low = 0 for a normal stop bit, else number of bit periods the line stays low.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input int stop_low);
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(BIT);
    end
`ifdef UART_CMD_PARITY_EN
    rx = (^d) ^ bad_par;
    wait_clk(BIT);
`else
    if (bad_par) rx = 1'b1;
`endif
    if (stop_low == 0) begin
      rx = 1'b1;
      wait_clk(BIT);
    end else begin
      rx = 1'b0;
      wait_clk(stop_low * BIT);
      rx = 1'b1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_clear"},   int'(o_btn_clear),   0);
    chk({tag, "_runstop"}, int'(o_btn_runstop), 0);
    chk({tag, "_mode"},    int'(o_sw_mode),     0);
    chk({tag, "_data"},    int'(o_rx_data),     0);
    chk({tag, "_valid"},   int'(o_rx_valid),    0);
    chk({tag, "_ferr"},    int'(o_frame_err),   0);
  endtask

  initial begin
    logic [7:0] b;
    int guard;
    reset = 1'b1;
    rx    = 1'b1;
    wait_clk(3);
    check_outputs_zero("reset");
    reset = 1'b0;
    wait_clk(2);
    mon_hold = 1'b0;
    wait_clk(2 * BIT);

    // 'R' -> valid then runstop
    push(EV_VALID, 8'h52); push(EV_RUN, 8'h00);
    send_frame(8'h52, 1'b0, 0);
    wait_clk(2 * BIT);

    // 'c','M','M' back-to-back
    push(EV_VALID, 8'h63); push(EV_CLEAR, 8'h00);
    push(EV_VALID, 8'h4D); push(EV_MODE, 8'h01);
    push(EV_VALID, 8'h4D); push(EV_MODE, 8'h00);
    send_frame(8'h63, 1'b0, 0);
    send_frame(8'h4D, 1'b0, 0);
    send_frame(8'h4D, 1'b0, 0);
    wait_clk(2 * BIT);
    chk("data_after_mm", int'(o_rx_data), 8'h4D);

    // short glitch then 'A'
    rx = 1'b0;
    wait_clk(3 * DIVN);
    rx = 1'b1;
    wait_clk(2 * BIT);
    push(EV_VALID, 8'h41);
    send_frame(8'h41, 1'b0, 0);
    wait_clk(2 * BIT);

    // break on stop bit, then 'R'
    push(EV_FERR, 8'h00);
    send_frame(8'h52, 1'b0, 20);
    wait_clk(3 * BIT);
    push(EV_VALID, 8'h52); push(EV_RUN, 8'h00);
    send_frame(8'h52, 1'b0, 0);
    wait_clk(2 * BIT);

    // 'm' so mode is 1, then reset during bit 4 of 'r'
    push(EV_VALID, 8'h6D); push(EV_MODE, 8'h01);
    send_frame(8'h6D, 1'b0, 0);
    wait_clk(2 * BIT);
    chk("mode_before_reset", int'(o_sw_mode), 1);
    b = 8'h72;
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_clk(BIT);
    end
    rx = b[4];
    wait_clk(BIT / 2);
    mon_hold = 1'b1;
    reset = 1'b1;
    wait_clk(1);
    check_outputs_zero("midreset");
    rx = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    wait_clk(2);
    mon_hold = 1'b0;
    wait_clk(3 * BIT);
    push(EV_VALID, 8'h72); push(EV_RUN, 8'h00);
    send_frame(8'h72, 1'b0, 0);
    wait_clk(2 * BIT);

`ifdef UART_CMD_PARITY_EN
    push(EV_FERR, 8'h00);
    send_frame(8'h43, 1'b1, 0);
    wait_clk(2 * BIT);
    push(EV_VALID, 8'h43); push(EV_CLEAR, 8'h00);
    send_frame(8'h43, 1'b0, 0);
    wait_clk(2 * BIT);
`endif

    guard = 0;
    while (q.size() != 0 && guard < 20 * BIT) begin
      wait_clk(1);
      guard++;
    end
    chk("queue_drained", q.size(), 0);
    chk("final_mode", int'(o_sw_mode), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
